// File: rtl/exe_defs.sv
// Shared definitions for the EXE stage: ALU op codes, multiplier FSM encoding
// and the multiplier step count.
package exe_defs;

    localparam logic [3:0] ALUC_ADD  = 4'h0;
    localparam logic [3:0] ALUC_SUB  = 4'h1;
    localparam logic [3:0] ALUC_AND  = 4'h2;
    localparam logic [3:0] ALUC_OR   = 4'h3;
    localparam logic [3:0] ALUC_XOR  = 4'h4;
    localparam logic [3:0] ALUC_NOR  = 4'h5;
    localparam logic [3:0] ALUC_SLT  = 4'h6;
    localparam logic [3:0] ALUC_SLTU = 4'h7;
    localparam logic [3:0] ALUC_SLL  = 4'h8;
    localparam logic [3:0] ALUC_SRL  = 4'h9;
    localparam logic [3:0] ALUC_SRA  = 4'hA;
    localparam logic [3:0] ALUC_LUI  = 4'hB;
    localparam logic [3:0] ALUC_MUL  = 4'hC;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    localparam int MUL_STEPS = 32;

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier: one load cycle, MUL_STEPS add/shift cycles,
// then one DONE cycle in which product holds the low word of a*b.
module seq_mul import exe_defs::*; #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(MUL_STEPS);

    mul_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] prod_q, prod_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MUL_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        case (state_q)
            MUL_IDLE: begin
                // start is only honoured here, so DONE cannot relaunch the same MUL
                if (start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    prod_d   = '0;
                    cnt_d    = CNT_W'(MUL_STEPS - 1);
                    state_d  = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = MUL_DONE;
                end
            end
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    assign busy    = (state_q == MUL_BUSY);
    assign done    = (state_q == MUL_DONE);
    assign product = prod_q;

endmodule

// File: rtl/exe_stage_mem_reg.sv
// MIPS EXE stage (operand select, ALU, destination select, branch resolve)
// followed by the EXE/MEM pipeline register; MUL stalls upstream while it iterates.
module exe_stage_mem_reg import exe_defs::*; #(
    parameter int DATA_W = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ewreg,
    input  logic              em2reg,
    input  logic              ewmem,
    input  logic              eshift,
    input  logic              ealuimm,
    input  logic [3:0]        ealuc,
    input  logic [DATA_W-1:0] ea,
    input  logic [DATA_W-1:0] eb,
    input  logic [DATA_W-1:0] eimm,
    input  logic              e_branch,
    input  logic [DATA_W-1:0] e_pc4,
    input  logic              e_regrt,
    input  logic [4:0]        e_rt,
    input  logic [4:0]        e_rd,
    input  logic [3:0]        EXE_ins_type,
    input  logic [3:0]        EXE_ins_number,
    output logic              ex_stall,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_target,
    output logic [4:0]        e_rn,
    output logic              m_wreg,
    output logic              m_m2reg,
    output logic              m_wmem,
    output logic [DATA_W-1:0] m_alu,
    output logic [DATA_W-1:0] m_b,
    output logic [4:0]        m_rn,
    output logic [3:0]        MEM_ins_type,
    output logic [3:0]        MEM_ins_number
);

    logic [DATA_W-1:0] op_a, op_b, alu_res, mul_product;
    logic [4:0]        shamt;
    logic              mul_start, mul_busy, mul_done;

    logic              wreg_q, m2reg_q, wmem_q;
    logic [DATA_W-1:0] alu_q, b_q;
    logic [4:0]        rn_q;
    logic [3:0]        type_q, number_q;

    assign op_a  = eshift ? {{(DATA_W-5){1'b0}}, eimm[10:6]} : ea;
    assign op_b  = ealuimm ? eimm : eb;
    assign shamt = op_a[4:0];
    assign e_rn  = e_regrt ? e_rt : e_rd;

    assign mul_start = MUL_EN && (ealuc == ALUC_MUL);

    seq_mul #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // In DONE the MUL is still in EXE but its result is ready, so the stall lifts
    assign ex_stall = mul_busy | (mul_start & ~mul_done);

    always_comb begin
        alu_res = '0;
        case (ealuc)
            ALUC_ADD:  alu_res = op_a + op_b;
            ALUC_SUB:  alu_res = op_a - op_b;
            ALUC_AND:  alu_res = op_a & op_b;
            ALUC_OR:   alu_res = op_a | op_b;
            ALUC_XOR:  alu_res = op_a ^ op_b;
            ALUC_NOR:  alu_res = ~(op_a | op_b);
            ALUC_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALUC_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
            ALUC_SLL:  alu_res = op_b << shamt;
            ALUC_SRL:  alu_res = op_b >> shamt;
            ALUC_SRA:  alu_res = $unsigned($signed(op_b) >>> shamt);
            ALUC_LUI:  alu_res = {op_b[15:0], 16'h0000};
            ALUC_MUL:  alu_res = MUL_EN ? mul_product : '0;
            default:   alu_res = '0;
        endcase
    end

    assign branch_taken  = e_branch & (ea == eb) & ~ex_stall;
    assign branch_target = e_pc4 + {eimm[DATA_W-3:0], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wreg_q   <= 1'b0;
            m2reg_q  <= 1'b0;
            wmem_q   <= 1'b0;
            alu_q    <= '0;
            b_q      <= '0;
            rn_q     <= '0;
            type_q   <= '0;
            number_q <= '0;
        end else if (ex_stall) begin
            // bubble: kill control, keep datapath values
            wreg_q   <= 1'b0;
            m2reg_q  <= 1'b0;
            wmem_q   <= 1'b0;
            rn_q     <= '0;
            type_q   <= '0;
            number_q <= '0;
        end else begin
            wreg_q   <= ewreg;
            m2reg_q  <= em2reg;
            wmem_q   <= ewmem;
            alu_q    <= alu_res;
            b_q      <= eb;
            rn_q     <= e_rn;
            type_q   <= EXE_ins_type;
            number_q <= EXE_ins_number;
        end
    end

    assign m_wreg         = wreg_q;
    assign m_m2reg        = m2reg_q;
    assign m_wmem         = wmem_q;
    assign m_alu          = alu_q;
    assign m_b            = b_q;
    assign m_rn           = rn_q;
    assign MEM_ins_type   = type_q;
    assign MEM_ins_number = number_q;

endmodule
